// File: rtl/vector_magnitude_seq.sv
// Purpose : sequential magnitude unit over N = x*x + y*y. Each transaction returns
//           floor(sqrt(N)), round(sqrt(N)) or ceil(log2(N)), plus an exactness flag.
// Latency : out_valid rises W+2 edges after the accepting edge. Accepts are at least W+4 cycles apart.
// Backpr. : the result holds in DONE while out_ready=0, and in_ready stays 0 until it is consumed.
// Ports   : clk/rst (async, active-high); in_valid/in_ready/in_x/in_y/in_mode;
//           out_valid/out_ready/out_mag[W:0]/out_exact.
module vector_magnitude_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_mag,
    output logic         out_exact
);
    localparam int NW = 2 * W + 2;       // radicand width, always even
    localparam int RW = W + 4;           // remainder working width
    localparam int CW = $clog2(W + 2);   // iteration counter width

    typedef enum logic [1:0] {IDLE, SQ, ROOT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic [1:0]     mode_q, mode_d;
    logic [NW-1:0]  n_q, n_d;            // full radicand, kept for the log2 path
    logic [NW-1:0]  n_sh_q, n_sh_d;      // radicand shifted left 2 bits per iteration
    logic [W:0]     root_q, root_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [W:0]     out_mag_q, out_mag_d;
    logic           out_exact_q, out_exact_d;
    logic           in_ready_q, in_ready_d;

    // Single restoring iteration
    logic [NW-1:0]  xx, yy, sq_sum;
    logic [RW-1:0]  rem_sh, trial, rem_it;
    logic [W:0]     root_it, round_mag;
    logic [NW-1:0]  n_m1;
    logic [W:0]     lg;
    logic           pow2;

    always_comb begin
        xx     = {{(W + 2){1'b0}}, x_q};
        yy     = {{(W + 2){1'b0}}, y_q};
        sq_sum = xx * xx + yy * yy;

        // Bring down the next bit pair and test it against (4*root + 1).
        rem_sh = {rem_q[RW-3:0], n_sh_q[NW-1 -: 2]};
        trial  = {1'b0, root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_it  = rem_sh - trial;
            root_it = {root_q[W-1:0], 1'b1};
        end else begin
            rem_it  = rem_sh;
            root_it = {root_q[W-1:0], 1'b0};
        end

        // The remainder is past the midpoint (r + 0.5)^2 exactly when rem > r.
        // The integer compare is exact because r^2 + r + 0.25 is never an integer.
        round_mag = ({3'b000, root_it} < rem_it) ? root_it + 1'b1 : root_it;

        // ceil(log2(N)) is one more than the index of the highest set bit of N-1.
        // The N<=1 guard also covers the N-1 underflow at N=0.
        n_m1 = n_q - 1'b1;
        lg   = '0;
        for (int i = 0; i < NW; i++) begin
            if (n_m1[i]) lg = (W + 1)'(i + 1);
        end
        if (n_q <= NW'(1)) lg = '0;
        pow2 = ((n_q & n_m1) == '0);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        n_d         = n_q;
        n_sh_d      = n_sh_q;
        root_d      = root_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_mag_d   = out_mag_q;
        out_exact_d = out_exact_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    mode_d  = (in_mode == 2'b11) ? 2'b00 : in_mode;
                    state_d = SQ;
                end
            end
            SQ: begin
                n_d     = sq_sum;
                n_sh_d  = sq_sum;
                root_d  = '0;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = ROOT;
            end
            ROOT: begin
                root_d = root_it;
                rem_d  = rem_it;
                n_sh_d = n_sh_q << 2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    case (mode_q)
                        2'b01:   begin out_mag_d = round_mag; out_exact_d = (rem_it == '0); end
                        2'b10:   begin out_mag_d = lg;        out_exact_d = pow2;           end
                        default: begin out_mag_d = root_it;   out_exact_d = (rem_it == '0); end
                    endcase
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            n_q         <= '0;
            n_sh_q      <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_exact_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            n_sh_q      <= n_sh_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_mag_q   <= out_mag_d;
            out_exact_q <= out_exact_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_exact = out_exact_q;
endmodule

// File: tb/tb_vector_magnitude_seq.sv
module tb_vector_magnitude_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   out_mag;
    logic         out_exact;

    int checks = 0;
    int errors = 0;

    vector_magnitude_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_exact (out_exact)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int mode;
        int mag;
        int exact;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait for in_ready, present one transaction, check its latency and result, then consume it.
    task automatic do_txn(input string name, input int x, input int y, input int mode,
                          input int exp_mag, input int exp_exact);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, " in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_x     = W'(x);
        in_y     = W'(y);
        in_mode  = 2'(mode);
        @(posedge clk); #1;                      // accepting edge
        in_valid = 1'b0;
        in_x     = W'($urandom);
        in_y     = W'($urandom);
        in_mode  = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, 10);
        check({name, " mag"}, int'(out_mag), exp_mag);
        check({name, " exact"}, int'(out_exact), exp_exact);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " valid drop"}, int'(out_valid), 0);
    endtask

    vec_t vecs[$];

    initial begin
        int bad;
        int spurious;
        string nm;

        vecs.push_back('{3,   4,   0, 5,   1});
        vecs.push_back('{255, 255, 0, 360, 0});
        vecs.push_back('{255, 255, 1, 361, 0});
        vecs.push_back('{255, 255, 2, 17,  0});
        vecs.push_back('{0,   0,   0, 0,   1});
        vecs.push_back('{0,   0,   2, 0,   1});
        vecs.push_back('{1,   1,   1, 1,   0});
        vecs.push_back('{1,   1,   2, 1,   1});
        vecs.push_back('{5,   12,  3, 13,  1});
        vecs.push_back('{1,   0,   2, 0,   1});   // N=1
        vecs.push_back('{3,   3,   1, 4,   0});   // N=18, rem 2 <= 4
        vecs.push_back('{7,   7,   1, 10,  0});   // N=98, rem 17 > 9
        vecs.push_back('{2,   3,   2, 4,   0});   // N=13
        vecs.push_back('{4,   4,   2, 5,   1});   // N=32
        vecs.push_back('{255, 0,   0, 255, 1});
        vecs.push_back('{200, 100, 1, 224, 0});   // N=50000, rem 271 > 223

        // Outputs while reset is held
        #12;
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_mag", int'(out_mag), 0);
        check("reset out_exact", int'(out_exact), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            nm = $sformatf("vec%0d", i);
            do_txn(nm, vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].mag, vecs[i].exact);
        end

        // Backpressure: result held in DONE for 20 cycles while in_valid stays high with changing operands
        begin
            int lat;
            in_valid = 1'b1; in_x = 8'd9; in_y = 8'd12; in_mode = 2'b00;
            @(posedge clk); #1;
            lat = 0;
            while (!out_valid && lat < 40) begin
                in_x = W'($urandom); in_y = W'($urandom); in_mode = 2'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            check("bp latency", lat, 10);
            check("bp mag", int'(out_mag), 15);
            bad = 0;
            for (int c = 0; c < 20; c++) begin
                in_x = W'($urandom); in_y = W'($urandom); in_mode = 2'($urandom);
                @(posedge clk); #1;
                if (out_mag != 9'd15 || in_ready || !out_valid || !out_exact) bad++;
            end
            check("bp stable cycles bad", bad, 0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp valid drop", int'(out_valid), 0);
            check("bp in_ready after", int'(in_ready), 1);
            check("bp mag retained", int'(out_mag), 15);
        end

        // Reset four cycles into ROOT aborts the transaction
        in_valid = 1'b1; in_x = 8'd200; in_y = 8'd100; in_mode = 2'b01;
        @(posedge clk); #1;                      // accept -> SQ
        in_valid = 1'b0;
        @(posedge clk); #1;                      // SQ -> ROOT
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("abort out_valid", int'(out_valid), 0);
        check("abort out_mag", int'(out_mag), 0);
        check("abort in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check("abort spurious", spurious, 0);
        do_txn("post-reset", 6, 8, 0, 10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/vector_magnitude_seq.md
Name: vector_magnitude_seq

Overview:
- Sequential, parametrised vector-magnitude unit. Computes N = x² + y² from two unsigned W-bit operands.
- Returns one of three results, chosen per transaction:
  - floor(sqrt(N))
  - round-to-nearest sqrt(N)
  - ceil(log2(N))
- Replaces the fixed 8-bit table-based magnitude block with an iterative digit-by-digit square root. Valid/ready handshakes are on both sides, and latency is constant.
- Sits between the tile input pins (X on ui_in, Y on uio_in) and the registered output pins.

Parameters:
- W, 8, operand width in bits. Legal range 2..16. Result width is W+1. Sum width is 2W+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand/mode presented
- in_ready  output  1  block can accept a transaction
- in_x  input  W  unsigned X operand
- in_y  input  W  unsigned Y operand
- in_mode  input  2  00 floor sqrt, 01 rounded sqrt, 10 ceil log2, 11 treated as 00
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_mag  output  W+1  result
- out_exact  output  1  sqrt modes: N is a perfect square (remainder 0); log2 mode: N is 0 or a power of two

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst is high:
  - state = IDLE, out_valid = 0, out_mag = 0, out_exact = 0, and all internal registers are cleared.
  - in_ready is forced to 0.
- Reset asserted mid-transaction aborts it. No result is emitted.
- States and transitions:
  - IDLE: in_ready = 1.
    - Accept when in_valid && in_ready.
    - Latch in_x, in_y and in_mode (11 maps to 00), then go to SQ.
  - SQ: one cycle. Register N = in_x*in_x + in_y*in_y, 2W+1 bits, zero-extended to 2W+2 bits. Clear root and remainder, set iteration count to 0, go to ROOT.
  - ROOT: exactly W+1 cycles of the restoring digit-by-digit square root, 2 bits of N per cycle, MSB pair first. Runs for every mode so latency is constant.
    - After the last iteration, compute the final result and go to DONE.
    - Sqrt final result: root r = floor(sqrt(N)), remainder rem = N - r².
    - Floor mode: out_mag = r.
    - Round mode: out_mag = r + 1 if rem > r, else r.
    - log2 mode: out_mag = ceil(log2(N)), with N = 0 and N = 1 giving 0. Zero-extended to W+1 bits.
    - out_exact: rem == 0 in sqrt modes; N has at most one bit set in log2 mode.
  - DONE: out_valid = 1.
    - out_mag and out_exact hold stable while out_ready = 0.
    - When out_ready = 1, clear out_valid and go to IDLE.
    - in_ready stays 0 in DONE, so there is no accept in the same cycle as the result is consumed.
- Latency and throughput:
  - out_valid rises W+2 clock edges after the accepting edge (10 for W=8).
  - Minimum spacing between accepts is W+4 cycles.
- Width rules:
  - Maximum rounded result round((2^W-1)·√2) always fits in W+1 bits, so there is no saturation.
  - Round-mode increment uses W+1-bit arithmetic.
- in_x, in_y and in_mode are ignored outside the accepting cycle.
- out_mag retains its last value after the result is consumed, until the next result is loaded; only out_valid qualifies it.

Test Plan (W=8):
- Reset, then accept x=3, y=4, mode 00 -> out_valid exactly 10 edges after the accept edge; out_mag=5, out_exact=1.
- x=255, y=255 (N=130050):
  - mode 00 -> 360, exact=0
  - mode 01 -> 361, exact=0
  - mode 10 -> 17, exact=0
- x=0, y=0:
  - mode 00 -> 0, exact=1
  - mode 10 -> 0, exact=1
- x=1, y=1 (N=2):
  - mode 01 -> 1
  - mode 10 -> 1, exact=1
- x=5, y=12, mode 11 -> 13, exact=1.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 and changing operands -> out_mag stable, in_ready=0 throughout. Then raise out_ready -> out_valid drops next edge, and in_ready=1 the cycle after.
- Assert rst 4 cycles into ROOT -> out_valid=0 and out_mag=0 immediately (asynchronous), with no spurious result afterwards. Release rst and run x=6, y=8 -> 10 with normal latency.
